// File: rtl/tri_setup_seq_pkg.sv
// Shared definitions for the triangle-setup sequencer and its helpers.
package tri_setup_pkg;

  // Default coordinate width per axis and the exact difference width.
  localparam int COORD_W_DEFAULT = 11;
  localparam int DIFF_W_DEFAULT  = COORD_W_DEFAULT + 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIN  = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Shared-subtractor operation indices; bit 0 selects the axis (0=x, 1=y).
  localparam logic [3:0] OP_P1P2_X  = 4'd0;
  localparam logic [3:0] OP_P1P2_Y  = 4'd1;
  localparam logic [3:0] OP_P2P3_X  = 4'd2;
  localparam logic [3:0] OP_P2P3_Y  = 4'd3;
  localparam logic [3:0] OP_P3P1_X  = 4'd4;
  localparam logic [3:0] OP_P3P1_Y  = 4'd5;
  localparam logic [3:0] OP_P1MIN_X = 4'd6;
  localparam logic [3:0] OP_P1MIN_Y = 4'd7;
  localparam logic [3:0] OP_P2MIN_X = 4'd8;
  localparam logic [3:0] OP_P2MIN_Y = 4'd9;
  localparam logic [3:0] OP_P3MIN_X = 4'd10;
  localparam logic [3:0] OP_P3MIN_Y = 4'd11;
  localparam int         NUM_OPS    = 12;

  // Minimum-vertex codes.
  localparam logic [1:0] MINP_P1 = 2'd0;
  localparam logic [1:0] MINP_P2 = 2'd1;
  localparam logic [1:0] MINP_P3 = 2'd2;

endpackage

// File: rtl/tri_setup_seq_if.sv
// Triangle-in / setup-bundle-out handshake bundle for the sequencer.
interface tri_setup_seq_if #(
  parameter int COORD_W = tri_setup_pkg::COORD_W_DEFAULT,
  parameter int DIFF_W  = COORD_W + 1
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2*COORD_W-1:0]  p1;
  logic [2*COORD_W-1:0]  p2;
  logic [2*COORD_W-1:0]  p3;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            minp;
  logic [2*DIFF_W-1:0]   diff_p1p2;
  logic [2*DIFF_W-1:0]   diff_p2p3;
  logic [2*DIFF_W-1:0]   diff_p3p1;
  logic [2*DIFF_W-1:0]   diff_p1min;
  logic [2*DIFF_W-1:0]   diff_p2min;
  logic [2*DIFF_W-1:0]   diff_p3min;
  logic                  busy;

  // Producer of triangles and consumer of bundles.
  modport master (
    output in_valid, p1, p2, p3, out_ready,
    input  in_ready, out_valid, minp, busy,
    input  diff_p1p2, diff_p2p3, diff_p3p1,
    input  diff_p1min, diff_p2min, diff_p3min
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, p1, p2, p3, out_ready,
    output in_ready, out_valid, minp, busy,
    output diff_p1p2, diff_p2p3, diff_p3p1,
    output diff_p1min, diff_p2min, diff_p3min
  );
endinterface

// File: rtl/tri_setup_seq_vtx_min_select.sv
// Combinational minimum-vertex selector: smallest y, then smallest x,
// then lowest index. Shared with the clipping stage.
module vtx_min_select
  import tri_setup_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [2*COORD_W-1:0] i_p1,
  input  logic [2*COORD_W-1:0] i_p2,
  input  logic [2*COORD_W-1:0] i_p3,
  output logic [1:0]           o_minp
);

  // Strict ordering: a comes before b. Strictness keeps the lower index on a full tie.
  function automatic logic below(input logic [2*COORD_W-1:0] a,
                                 input logic [2*COORD_W-1:0] b);
    logic signed [COORD_W-1:0] ax, ay, bx, by;
    ax = a[2*COORD_W-1:COORD_W];
    ay = a[COORD_W-1:0];
    bx = b[2*COORD_W-1:COORD_W];
    by = b[COORD_W-1:0];
    return (ay < by) || ((ay == by) && (ax < bx));
  endfunction

  logic [2*COORD_W-1:0] w_best;

  // Running minimum across the three vertices in index order.
  always_comb begin
    w_best = i_p1;
    o_minp = MINP_P1;
    if (below(i_p2, w_best)) begin
      w_best = i_p2;
      o_minp = MINP_P2;
    end
    if (below(i_p3, w_best)) begin
      w_best = i_p3;
      o_minp = MINP_P3;
    end
  end

endmodule

// File: rtl/tri_setup_seq.sv
// Triangle-setup sequencer: latches a triangle, picks its minimum vertex,
// then runs twelve subtractions through one shared subtractor and hands the
// whole result bundle to the edge-function stage.
module tri_setup_seq
  import tri_setup_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int DIFF_W  = COORD_W + 1
) (
  input logic            clk,
  input logic            rst_n,
  tri_setup_seq_if.slave bus
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_in_ready;
  logic                      w_busy;

  logic [2*COORD_W-1:0]      r_p1, r_p2, r_p3;
  logic [1:0]                r_minp;
  logic [1:0]                w_minp;
  logic [3:0]                r_op;
  logic                      r_out_valid;
  logic signed [DIFF_W-1:0]  r_res [NUM_OPS];

  logic [2*COORD_W-1:0]      w_pmin;
  logic [2*COORD_W-1:0]      w_va, w_vb;
  logic signed [COORD_W-1:0] w_opa, w_opb;
  logic signed [DIFF_W-1:0]  w_ext_a, w_ext_b, w_sub;

  function automatic logic signed [COORD_W-1:0] vx(input logic [2*COORD_W-1:0] v);
    return v[2*COORD_W-1:COORD_W];
  endfunction

  function automatic logic signed [COORD_W-1:0] vy(input logic [2*COORD_W-1:0] v);
    return v[COORD_W-1:0];
  endfunction

  vtx_min_select #(.COORD_W(COORD_W)) u_min_sel (
    .i_p1   (r_p1),
    .i_p2   (r_p2),
    .i_p3   (r_p3),
    .o_minp (w_minp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: one accept, one min cycle, twelve ops, then hold until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)                 w_state_nxt = ST_MIN;
      ST_MIN:                                    w_state_nxt = ST_SUB;
      ST_SUB:  if (r_op == OP_P3MIN_Y)           w_state_nxt = ST_DONE;
      ST_DONE: if (r_out_valid && bus.out_ready) w_state_nxt = ST_IDLE;
      default:                                   w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    w_in_ready = (r_state == ST_IDLE);
    w_busy     = (r_state != ST_IDLE);
  end

  // Vertex latch on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
    end else if (r_state == ST_IDLE && bus.in_valid) begin
      r_p1 <= bus.p1;
      r_p2 <= bus.p2;
      r_p3 <= bus.p3;
    end
  end

  // Minimum vertex is captured at the end of the MIN cycle and held for the min ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_minp <= MINP_P1;
    else if (r_state == ST_MIN) r_minp <= w_minp;
  end

  // Op counter: cleared entering SUB, advances once per SUB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_op <= '0;
    else if (r_state == ST_MIN) r_op <= '0;
    else if (r_state == ST_SUB) r_op <= r_op + 4'd1;
  end

  // Operand mux: op[3:1] picks the vertex pair, op[0] picks the axis.
  always_comb begin
    w_pmin = r_p1;
    w_va   = r_p1;
    w_vb   = r_p2;
    case (r_minp)
      MINP_P2: w_pmin = r_p2;
      MINP_P3: w_pmin = r_p3;
      default: w_pmin = r_p1;
    endcase
    case (r_op[3:1])
      3'd0:    begin w_va = r_p1; w_vb = r_p2;   end
      3'd1:    begin w_va = r_p2; w_vb = r_p3;   end
      3'd2:    begin w_va = r_p3; w_vb = r_p1;   end
      3'd3:    begin w_va = r_p1; w_vb = w_pmin; end
      3'd4:    begin w_va = r_p2; w_vb = w_pmin; end
      3'd5:    begin w_va = r_p3; w_vb = w_pmin; end
      default: begin w_va = r_p1; w_vb = r_p2;   end
    endcase
    w_opa = r_op[0] ? vy(w_va) : vx(w_va);
    w_opb = r_op[0] ? vy(w_vb) : vx(w_vb);
  end

  // One extra bit after sign extension makes every difference exact.
  assign w_ext_a = {{(DIFF_W-COORD_W){w_opa[COORD_W-1]}}, w_opa};
  assign w_ext_b = {{(DIFF_W-COORD_W){w_opb[COORD_W-1]}}, w_opb};
  assign w_sub   = w_ext_a - w_ext_b;

  // Result file: each op's difference is written at the end of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) r_res[i] <= '0;
    end else if (r_state == ST_SUB) begin
      r_res[r_op] <= w_sub;
    end
  end

  // Output valid is registered from DONE and dropped on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_valid <= 1'b0;
    else        r_out_valid <= (r_state == ST_DONE) && !(r_out_valid && bus.out_ready);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = w_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.minp       = r_minp;
  assign bus.diff_p1p2  = {r_res[OP_P1P2_X],  r_res[OP_P1P2_Y]};
  assign bus.diff_p2p3  = {r_res[OP_P2P3_X],  r_res[OP_P2P3_Y]};
  assign bus.diff_p3p1  = {r_res[OP_P3P1_X],  r_res[OP_P3P1_Y]};
  assign bus.diff_p1min = {r_res[OP_P1MIN_X], r_res[OP_P1MIN_Y]};
  assign bus.diff_p2min = {r_res[OP_P2MIN_X], r_res[OP_P2MIN_Y]};
  assign bus.diff_p3min = {r_res[OP_P3MIN_X], r_res[OP_P3MIN_Y]};

endmodule

// File: doc/tri_setup_seq.md
Name: tri_setup_seq

Overview:
- Triangle-setup sequencer for the rasterizer front end.
- Accepts one triangle (three signed 2-D vertices p1, p2, p3) over a valid/ready handshake and selects the minimum vertex (minp).
- Time-multiplexes a single shared (COORD_W+1)-bit subtractor to produce the edge differences (p1-p2, p2-p3, p3-p1) and the vertex-to-min differences (p1-minp, p2-minp, p3-minp).
- Presents all results together over an output valid/ready handshake to the edge-function stage.

Parameters:
- COORD_W, 11, signed coordinate width per axis (range -1024..1023).
- DIFF_W, COORD_W+1, signed difference width per axis; cannot overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  triangle present on p1/p2/p3.
- in_ready  out  1  sequencer can accept a triangle.
- p1, p2, p3  in  2*COORD_W each  vertex {x[2W-1:W], y[W-1:0]}, signed.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- minp  out  2  index of min vertex: 0=p1, 1=p2, 2=p3.
- diff_p1p2, diff_p2p3, diff_p3p1  out  2*DIFF_W each  {dx, dy}, computed as first vertex minus second.
- diff_p1min, diff_p2min, diff_p3min  out  2*DIFF_W each  {dx, dy} = pN - p[minp].
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - state=IDLE.
  - All diff outputs = 0, minp = 0, out_valid = 0, busy = 0.
  - in_ready = 1. It is decoded from state == IDLE, so it reads 1 while rst_n is low.
  - Latched vertices are cleared; a partial sequence is discarded.
- State machine: IDLE -> MIN -> SUB -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: latch p1/p2/p3 and go to MIN.
  - in_valid without an accepting edge has no effect.
- MIN (cycle T+1): register minp. Selection rule:
  - smallest y;
  - tie on y -> smallest x;
  - full tie -> lowest index.
- SUB (cycles T+2..T+13): a 4-bit op counter (0..11) selects the operand pair, one op per cycle. Each result is registered at the end of its cycle. Op order:
  - ops 0-1: x, y of p1-p2
  - ops 2-3: x, y of p2-p3
  - ops 4-5: x, y of p3-p1
  - ops 6-7: x, y of p1-min
  - ops 8-9: x, y of p2-min
  - ops 10-11: x, y of p3-min
  - Operands are sign-extended to DIFF_W before subtraction; the result is exact, with no saturation or wrap.
  - After op 11: go to DONE.
- DONE (from T+14): out_valid = 1.
  - All outputs are held stable while out_ready = 0 (unlimited backpressure).
  - On out_valid & out_ready: go to IDLE; out_valid = 0 the next cycle; in_ready = 1 the next cycle.
- Throughput: accept-to-out_valid latency 14 cycles. At most one triangle in flight. in_ready = 0 from T+1 until return to IDLE.
- Diff and minp outputs keep the last bundle's values after handshake until the next sequence overwrites them. They are only meaningful while out_valid = 1.
- Min vertex: its own diff_pNmin is always {0, 0}.
- Input changes while not in IDLE are ignored.

Decomposition:
- Package tri_setup_pkg holds:
  - COORD_W and DIFF_W defaults;
  - the state encoding (IDLE, MIN, SUB, DONE);
  - op-index constants OP_P1P2_X .. OP_P3MIN_Y (0..11);
  - MINP_P1/P2/P3 codes.
- One sub-module: vtx_min_select. It is purely combinational: three vertices in, 2-bit minp out, implementing the tie-break rules. It is reused by the clipping stage.
- The subtractor and operand mux stay inline in tri_setup_seq.

Test Plan:
- Basic bundle:
  - Stimulus: p1=(10,20), p2=(30,5), p3=(15,5).
  - Required: minp=2 (y tie, x 15<30).
  - diff_p1p2=(-20,15), diff_p2p3=(15,0), diff_p3p1=(5,-15).
  - diff_p1min=(-5,15), diff_p2min=(15,0), diff_p3min=(0,0).
  - out_valid rises exactly 14 cycles after the accepting edge.
- Full tie:
  - Stimulus: p1=p2=p3=(7,-3).
  - Required: minp=0 and every diff = (0,0).
- Extremes:
  - Stimulus: p1=(-1024,-1024), p2=(1023,1023), p3=(0,0).
  - Required: minp=0, diff_p1p2=(-2047,-2047), diff_p2min=(2047,2047), diff_p3p1=(1024,1024). No overflow.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 carrying a new triangle.
  - Required: outputs unchanged, in_ready=0, second triangle not accepted.
  - Release out_ready: in_ready=1 the cycle after the handshake; second triangle accepted on the following edge.
- Reset mid-sequence:
  - Stimulus: pull rst_n low at T+6 (inside SUB) for 2 cycles.
  - Required: immediately busy=0, out_valid=0, all diffs=0, minp=0, in_ready=1.
  - A fresh triangle after release completes normally in 14 cycles.
- Back-to-back:
  - Stimulus: out_ready tied 1, in_valid tied 1 with two different triangles.
  - Required: second accept occurs 2 cycles after the first out_valid cycle, and the second bundle is correct.
